// File: rtl/ctrl_pkg.sv
// Shared opcode constants, FSM state, decode class and control-word layout
// for the control pipeline.
package ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int CNT_W = 4;

    // Opcode group prefixes (upper bits of the 5-bit opcode)
    localparam logic [1:0] OPP_ALU = 2'b00;
    localparam logic [1:0] OPP_IMM = 2'b01;
    localparam logic [2:0] OPP_CBR = 3'b101;
    localparam logic [2:0] OPP_SH  = 3'b110;

    // Exact opcodes
    localparam logic [4:0] OP_LW  = 5'b10000;
    localparam logic [4:0] OP_SW  = 5'b10001;
    localparam logic [4:0] OP_JMP = 5'b11100;
    localparam logic [4:0] OP_JSB = 5'b11101;
    localparam logic [4:0] OP_RET = 5'b11110;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        KILL    = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CLS_SEQ = 3'd0,
        CLS_CBR = 3'd1,
        CLS_JMP = 3'd2,
        CLS_JSB = 3'd3,
        CLS_RET = 3'd4
    } cmd_cls_e;

    typedef struct packed {
        logic       ctrl_valid;
        logic       ALU1_mux;
        logic       status_en;
        logic       ALU_o_sh;
        logic       ex_o_mem;
        logic       reg_write;
        logic       MemWen;
        logic       RegDst;
        logic       push;
        logic       pop;
        logic [1:0] shiftOp;
        logic [1:0] PCmux;
        logic [2:0] ALUop;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: produces the control word and a class tag the
// pipeline FSM uses for sequencing and return-stack bookkeeping.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int CMD_W = 5
) (
    input  logic [CMD_W-1:0] command,
    input  logic             full,
    input  logic             empty,
    output ctrl_word_t       word,
    output cmd_cls_e         cls
);

    logic [OP_W-1:0] op;
    logic            hi_zero;

    assign op = command[OP_W-1:0];

    // Any set bit above the base opcode makes the command illegal
    if (CMD_W > OP_W) begin : g_hi
        assign hi_zero = ~|command[CMD_W-1:OP_W];
    end else begin : g_nohi
        assign hi_zero = 1'b1;
    end

    always_comb begin
        word            = '0;
        word.ctrl_valid = 1'b1;
        cls             = CLS_SEQ;
        if (hi_zero) begin
            if (op[4:3] == OPP_ALU || op[4:3] == OPP_IMM) begin
                word.status_en = 1'b1;
                word.reg_write = 1'b1;
                word.ALU1_mux  = (op[4:3] == OPP_IMM);
                word.ALUop     = op[2:0];
            end else if (op[4:2] == OPP_SH) begin
                word.status_en = 1'b1;
                word.reg_write = 1'b1;
                word.ALU_o_sh  = 1'b1;
                word.shiftOp   = op[1:0];
            end else if (op[4:2] == OPP_CBR) begin
                cls = CLS_CBR;
            end else if (op == OP_LW) begin
                word.ALU1_mux  = 1'b1;
                word.ex_o_mem  = 1'b1;
                word.reg_write = 1'b1;
            end else if (op == OP_SW) begin
                word.ALU1_mux = 1'b1;
                word.ex_o_mem = 1'b1;
                word.MemWen   = 1'b1;
                word.RegDst   = 1'b1;
            end else if (op == OP_JMP) begin
                word.PCmux = 2'd2;
                cls        = CLS_JMP;
            end else if (op == OP_JSB) begin
                // A full stack still redirects; only the push is suppressed
                word.PCmux = 2'd2;
                word.push  = ~full;
                cls        = CLS_JSB;
            end else if (op == OP_RET) begin
                word.PCmux = 2'd3;
                word.pop   = ~empty;
                cls        = CLS_RET;
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: accepts commands, registers the decoded control word,
// stalls on conditional jumps and tracks return-stack depth.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int BR_LAT      = 2,
    parameter int STACK_DEPTH = 8,
    parameter int CMD_W       = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    input  logic [CMD_W-1:0]               command,
    input  logic                           br_taken,
    input  logic                           flush,
    output logic                           ctrl_valid,
    output logic                           ALU1_mux,
    output logic                           status_en,
    output logic                           ALU_o_sh,
    output logic                           ex_o_mem,
    output logic                           reg_write,
    output logic                           MemWen,
    output logic                           RegDst,
    output logic                           push,
    output logic                           pop,
    output logic [1:0]                     shiftOp,
    output logic [1:0]                     PCmux,
    output logic [2:0]                     ALUop,
    output logic                           stall,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           stack_err
);

    localparam int DW = $clog2(STACK_DEPTH) + 1;

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [DW-1:0]    depth_nxt;
    logic             err_nxt;
    logic             full, empty;
    ctrl_word_t       word_q, word_nxt, dec_word;
    cmd_cls_e         dec_cls;

    assign full  = (depth == DW'(STACK_DEPTH));
    assign empty = (depth == '0);
    assign stall = (state == BR_WAIT);

    ctrl_decode #(.CMD_W(CMD_W)) u_dec (
        .command (command),
        .full    (full),
        .empty   (empty),
        .word    (dec_word),
        .cls     (dec_cls)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        depth_nxt = depth;
        err_nxt   = stack_err;
        word_nxt  = '0;
        if (flush) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (cmd_valid) begin
                        word_nxt = dec_word;
                        case (dec_cls)
                            CLS_CBR: begin
                                state_nxt = BR_WAIT;
                                cnt_nxt   = CNT_W'(BR_LAT - 1);
                            end
                            CLS_JMP: state_nxt = KILL;
                            CLS_JSB: begin
                                state_nxt = KILL;
                                if (full) err_nxt = 1'b1;
                                else      depth_nxt = depth + DW'(1);
                            end
                            CLS_RET: begin
                                state_nxt = KILL;
                                if (empty) err_nxt = 1'b1;
                                else       depth_nxt = depth - DW'(1);
                            end
                            default: ;
                        endcase
                    end
                end
                BR_WAIT: begin
                    if (cnt == '0) begin
                        // Resolution word: valid either way, redirect only if taken
                        word_nxt.ctrl_valid = 1'b1;
                        if (br_taken) begin
                            word_nxt.PCmux = 2'd1;
                            state_nxt      = KILL;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                KILL:    state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            depth     <= '0;
            stack_err <= 1'b0;
            word_q    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            depth     <= depth_nxt;
            stack_err <= err_nxt;
            word_q    <= word_nxt;
        end
    end

    assign ctrl_valid = word_q.ctrl_valid;
    assign ALU1_mux   = word_q.ALU1_mux;
    assign status_en  = word_q.status_en;
    assign ALU_o_sh   = word_q.ALU_o_sh;
    assign ex_o_mem   = word_q.ex_o_mem;
    assign reg_write  = word_q.reg_write;
    assign MemWen     = word_q.MemWen;
    assign RegDst     = word_q.RegDst;
    assign push       = word_q.push;
    assign pop        = word_q.pop;
    assign shiftOp    = word_q.shiftOp;
    assign PCmux      = word_q.PCmux;
    assign ALUop      = word_q.ALUop;

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter BR_LAT, default 2, meaning cycles a conditional jump stalls before br_taken is sampled (range 1..15).
REQ-002 Parameter STACK_DEPTH, default 8, meaning return-stack entries tracked (power of two, 2..64).
REQ-003 Parameter CMD_W, default 5, meaning opcode width; CMD_W>5 extends the decode with upper bits, which must be 0 for a legal command.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command present this cycle.
REQ-007 command  input  CMD_W  opcode (ALU 00xxx, ALU-imm 01xxx, shift 110xx, LW 10000, SW 10001, cond-jump 101xx, JMP 11100, JSB 11101, RET 11110).
REQ-008 br_taken  input  1  conditional-jump outcome, meaningful only in the last BR_WAIT cycle.
REQ-009 flush  input  1  external squash of the command in the current cycle.
REQ-010 ctrl_valid  output  1  registered control word is live.
REQ-011 ALU1_mux, status_en, ALU_o_sh, ex_o_mem, reg_write, MemWen, RegDst, push, pop  output  1 each  registered control bits.
REQ-012 shiftOp  output  2, PCmux  output  2, ALUop  output  3  registered control fields.
REQ-013 stall  output  1  upstream must hold command.
REQ-014 depth  output  $clog2(STACK_DEPTH)+1  current return-stack occupancy.
REQ-015 stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-016 All control outputs SHALL be registered: a command accepted in cycle N drives outputs in N+1, for one cycle only.
REQ-017 A command SHALL be accepted when cmd_valid=1, stall=0, flush=0 and the FSM is RUN; otherwise the next cycle's word SHALL be all-zero with ctrl_valid=0.
REQ-018 Decode SHALL be: ALU: status_en,reg_write=1, ALUop=cmd[2:0]; ALU-imm: same plus ALU1_mux=1; shift: status_en,reg_write,ALU_o_sh=1, shiftOp=cmd[1:0]; LW: ALU1_mux,ex_o_mem,reg_write=1, ALUop=0; SW: ALU1_mux,ex_o_mem,MemWen,RegDst=1, ALUop=0; JMP: PCmux=2; JSB: PCmux=2, push=1; RET: PCmux=3, pop=1; illegal: ctrl_valid=1, all other bits 0.
REQ-019 FSM states SHALL be RUN, BR_WAIT, KILL.
REQ-020 RUN: accepted cond-jump -> BR_WAIT with counter=BR_LAT-1, stall=1 from next cycle; accepted JMP/JSB/RET -> KILL; else stay RUN.
REQ-021 BR_WAIT: stall=1, counter decrements; at counter=0 sample br_taken: taken -> emit word with PCmux=1, go KILL; not taken -> emit zero word with ctrl_valid=1, go RUN.
REQ-022 KILL: stall=0, the command presented that cycle SHALL be discarded (no word, no depth change), then RUN.
REQ-023 depth SHALL increment on an accepted JSB when depth<STACK_DEPTH; JSB at depth=STACK_DEPTH SHALL set stack_err, emit push=0, still redirect PCmux=2.
REQ-024 depth SHALL decrement on an accepted RET when depth>0; RET at depth=0 SHALL set stack_err, emit pop=0, still PCmux=3.
REQ-025 flush SHALL have priority over all: in BR_WAIT or KILL it returns FSM to RUN next cycle with zero word; depth unchanged.

Reset
REQ-026 rst SHALL force FSM=RUN, counter=0, depth=0, stack_err=0, stall=0, all control outputs 0, ctrl_valid=0 next edge, including mid-BR_WAIT.

Structure
REQ-027 Opcode constants, state enum and the control-word struct SHALL live in shared package ctrl_pkg.
REQ-028 Combinational opcode decode SHALL be one sub-module ctrl_decode; ctrl_pipe owns FSM, counters and output register.

Verification
REQ-029 ADD 00010 then LW 10000 -> cycle+1 ALUop=2,reg_write=1; cycle+2 ex_o_mem=1,ALU1_mux=1.
REQ-030 BR_LAT=2, cond-jump 10100, br_taken=1 in last wait cycle -> stall=1 for 2 cycles, PCmux=1, following command discarded.
REQ-031 Nine JSB (with KILL gaps), STACK_DEPTH=8 -> depth=8, ninth push=0, stack_err=1, PCmux=2.
REQ-032 RET at depth=0 -> pop=0, PCmux=3, stack_err=1, depth=0.
REQ-033 rst asserted in BR_WAIT -> next cycle stall=0, ctrl_valid=0, depth=0; ADD accepted the cycle after rst drops.
REQ-034 flush during BR_WAIT -> FSM RUN next cycle, no PCmux=1 word emitted.
